// File: rtl/image_streamer_pkg.sv
// rtl/image_streamer_pkg.sv - shared constants and FSM encoding for the image streamer
package image_streamer_pkg;

  localparam int ROM_IMAGE_WIDTH   = 8;
  localparam int ROM_IMAGE_DEPTH_W = 8;
  localparam int IMAGE_COLS        = 4;
  localparam int IMAGE_ROWS        = 3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} img_stream_state_e;

endpackage

// File: rtl/image_streamer_if.sv
// rtl/image_streamer_if.sv - pixel stream with frame/line markers
interface image_streamer_if import image_streamer_pkg::*; #(
  parameter int WIDTH = ROM_IMAGE_WIDTH
) ();

  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  logic             sof;
  logic             eol;
  logic             eof;

  modport master (output valid, data, sof, eol, eof, input ready);
  modport slave  (input valid, data, sof, eol, eof, output ready);

endinterface

// File: rtl/fifo_2deep.sv
// rtl/fifo_2deep.sv - two-entry FIFO with a registered head word
module fifo_2deep #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] tail;

  // Caller guarantees no push when full and no pop when empty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_o  <= '0;
      tail    <= '0;
      count_o <= 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (count_o == 2'd0) head_o <= data_i;
          else                 tail   <= data_i;
          count_o <= count_o + 2'd1;
        end
        2'b01: begin
          head_o  <= tail;
          count_o <= count_o - 2'd1;
        end
        2'b11: begin
          if (count_o == 2'd1) begin
            head_o <= data_i;
          end else begin
            head_o <= tail;
            tail   <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/image_streamer.sv
// rtl/image_streamer.sv - walks rom_image from a base address and streams pixels with frame markers
module image_streamer import image_streamer_pkg::*; #(
  parameter int WIDTH    = ROM_IMAGE_WIDTH,
  parameter int ADDR_W   = ROM_IMAGE_DEPTH_W,
  parameter int IMG_COLS = IMAGE_COLS,
  parameter int IMG_ROWS = IMAGE_ROWS
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              rom_rd_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [WIDTH-1:0]  rom_data_i,
  image_streamer_if.master  m
);

  localparam int N     = IMG_COLS * IMG_ROWS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1;
  localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1;

  img_stream_state_e state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  rd_cnt;
  logic              inflight;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [1:0]        fifo_cnt;
  logic [2:0]        used;
  logic              pop;
  logic              last_col;
  logic              last_row;

  assign pop      = m.valid & m.ready;
  assign last_col = (col == COL_W'(IMG_COLS - 1));
  assign last_row = (row == ROW_W'(IMG_ROWS - 1));

  // Credits count both buffered words and the word still coming out of the ROM.
  assign used        = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign rom_rd_en_o = (state == ST_RUN) && (rd_cnt < CNT_W'(N)) && (used < 3'd2);
  assign rom_addr_o  = base + ADDR_W'(rd_cnt);

  fifo_2deep #(.WIDTH(WIDTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (inflight),
    .data_i  (rom_data_i),
    .pop_i   (pop),
    .head_o  (m.data),
    .count_o (fifo_cnt)
  );

  assign m.valid = (fifo_cnt != 2'd0);
  assign m.sof   = m.valid && (col == '0) && (row == '0);
  assign m.eol   = m.valid && last_col;
  assign m.eof   = m.valid && last_col && last_row;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      base     <= '0;
      rd_cnt   <= '0;
      inflight <= 1'b0;
      col      <= '0;
      row      <= '0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
    end else begin
      inflight <= rom_rd_en_o;
      done_o   <= 1'b0;
      if (rom_rd_en_o) rd_cnt <= rd_cnt + 1'b1;
      if (pop) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            base   <= base_addr_i;
            rd_cnt <= '0;
            col    <= '0;
            row    <= '0;
            busy_o <= 1'b1;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (rom_rd_en_o && (rd_cnt == CNT_W'(N - 1))) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          // Stay in DRAIN during the done cycle so a coincident start is ignored.
          if (done_o) begin
            state <= ST_IDLE;
          end else if (pop && m.eof) begin
            done_o <= 1'b1;
            busy_o <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_streamer.sv
// tb/tb_image_streamer.sv - scoreboard bench for image_streamer
module tb_image_streamer;
  import image_streamer_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // DUT A: 4x3 image, 8-bit address, ROM word = address
  logic       a_start = 1'b0;
  logic [7:0] a_base  = 8'h00;
  logic       a_busy, a_done, a_rd_en;
  logic [7:0] a_addr;
  logic [7:0] a_rom = 8'h00;
  image_streamer_if #(.WIDTH(8)) a_if ();
  image_streamer #(.WIDTH(8), .ADDR_W(8), .IMG_COLS(4), .IMG_ROWS(3)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(a_start), .base_addr_i(a_base),
    .busy_o(a_busy), .done_o(a_done), .rom_rd_en_o(a_rd_en), .rom_addr_o(a_addr),
    .rom_data_i(a_rom), .m(a_if)
  );
  always @(posedge clk) if (a_rd_en) a_rom <= a_addr;

  // DUT B: 2x2 image, 4-bit address, ROM word = {A, address}
  logic       b_start = 1'b0;
  logic [3:0] b_base  = 4'h0;
  logic       b_busy, b_done, b_rd_en;
  logic [3:0] b_addr;
  logic [7:0] b_rom = 8'h00;
  image_streamer_if #(.WIDTH(8)) b_if ();
  image_streamer #(.WIDTH(8), .ADDR_W(4), .IMG_COLS(2), .IMG_ROWS(2)) dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(b_start), .base_addr_i(b_base),
    .busy_o(b_busy), .done_o(b_done), .rom_rd_en_o(b_rd_en), .rom_addr_o(b_addr),
    .rom_data_i(b_rom), .m(b_if)
  );
  always @(posedge clk) if (b_rd_en) b_rom <= {4'hA, b_addr};

  // DUT C: 1x1 image, ROM word = address + 0x55
  logic       c_start = 1'b0;
  logic [7:0] c_base  = 8'h00;
  logic       c_busy, c_done, c_rd_en;
  logic [7:0] c_addr;
  logic [7:0] c_rom = 8'h00;
  image_streamer_if #(.WIDTH(8)) c_if ();
  image_streamer #(.WIDTH(8), .ADDR_W(8), .IMG_COLS(1), .IMG_ROWS(1)) dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(c_start), .base_addr_i(c_base),
    .busy_o(c_busy), .done_o(c_done), .rom_rd_en_o(c_rd_en), .rom_addr_o(c_addr),
    .rom_data_i(c_rom), .m(c_if)
  );
  always @(posedge clk) if (c_rd_en) c_rom <= c_addr + 8'h55;

  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];
  logic [3:0] b_addrs[$];

  int a_beats, a_first_valid, a_first_hs, a_last_hs, a_dones, a_done_cyc, a_start_cyc;
  int a_issued, a_popped, a_credit_viol;
  logic a_hold = 1'b0;
  logic [7:0] a_hold_data;
  int c_hs_cyc = -1, c_done_cyc = -2, c_dones = 0;

  always @(negedge clk) begin : mon_a
    beat_t e;
    if (rst) begin
      a_hold = 1'b0;
    end else begin
      if (a_done) begin a_dones++; a_done_cyc = cyc; end
      if (a_rd_en && (a_issued - a_popped - int'(a_if.valid && a_if.ready)) >= 2) a_credit_viol++;
      if (a_hold) begin
        chk("a_hold_valid", a_if.valid, 1);
        chk("a_hold_data", a_if.data, a_hold_data);
      end
      a_hold = 1'b0;
      if (a_if.valid) begin
        if (a_first_valid < 0) a_first_valid = cyc;
        if (a_if.ready) begin
          if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL a_extra_beat actual=%0d expected=none", a_if.data);
          end else begin
            e = qa.pop_front();
            chk("a_data", a_if.data, e.data);
            chk("a_sof", a_if.sof, e.sof);
            chk("a_eol", a_if.eol, e.eol);
            chk("a_eof", a_if.eof, e.eof);
          end
          a_beats++;
          if (a_first_hs < 0) a_first_hs = cyc + 1;
          a_last_hs = cyc + 1;
        end else begin
          a_hold = 1'b1;
          a_hold_data = a_if.data;
        end
      end
      if (a_rd_en) a_issued++;
      if (a_if.valid && a_if.ready) a_popped++;
    end
  end

  always @(negedge clk) begin : mon_bc
    beat_t e;
    if (!rst) begin
      if (b_rd_en) b_addrs.push_back(b_addr);
      if (b_if.valid && b_if.ready) begin
        if (qb.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_extra_beat actual=%0d expected=none", b_if.data);
        end else begin
          e = qb.pop_front();
          chk("b_data", b_if.data, e.data);
          chk("b_markers", {b_if.sof, b_if.eol, b_if.eof}, {e.sof, e.eol, e.eof});
        end
      end
      if (c_done) begin c_dones++; c_done_cyc = cyc; end
      if (c_if.valid && c_if.ready) begin
        c_hs_cyc = cyc + 1;
        if (qc.size() == 0) begin
          checks++; errors++;
          $display("FAIL c_extra_beat actual=%0d expected=none", c_if.data);
        end else begin
          e = qc.pop_front();
          chk("c_data", c_if.data, e.data);
          chk("c_markers", {c_if.sof, c_if.eol, c_if.eof}, {e.sof, e.eol, e.eof});
        end
      end
    end
  end

  task automatic prep_a(input logic [7:0] base);
    a_beats = 0; a_first_valid = -1; a_first_hs = -1; a_last_hs = -1;
    a_dones = 0; a_done_cyc = -2; a_credit_viol = 0;
    for (int i = 0; i < 12; i++)
      qa.push_back('{data: base + 8'(i), sof: (i == 0), eol: (i % 4 == 3), eof: (i == 11)});
  endtask

  task automatic start_a(input logic [7:0] base);
    @(posedge clk); #1;
    a_start = 1'b1; a_base = base;
    @(posedge clk); #1;
    a_start = 1'b0; a_base = 8'hFF;
    a_start_cyc = cyc;
    chk("a_busy_after_start", a_busy, 1);
  endtask

  logic [15:0] rdy_pat = 16'b1001_1010_0110_1101;

  initial begin
    a_if.ready = 1'b1; b_if.ready = 1'b1; c_if.ready = 1'b1;
    a_issued = 0; a_popped = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_rd_en", a_rd_en, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_valid_markers", {a_if.valid, a_if.sof, a_if.eol, a_if.eof}, 0);
    chk("rst_data", a_if.data, 0);

    // Frame 1: full throughput, extra starts mid-frame and on the done cycle
    prep_a(8'h00);
    start_a(8'h00);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #1;
      a_start = (a_beats == 5) || a_done;
    end
    a_start = 1'b0;
    chk("f1_latency", a_first_valid - a_start_cyc, 2);
    chk("f1_no_bubbles", a_last_hs - a_first_hs, 11);
    chk("f1_beats", a_beats, 12);
    chk("f1_dones", a_dones, 1);
    chk("f1_done_timing", a_done_cyc, a_last_hs);
    chk("f1_queue_empty", qa.size(), 0);
    chk("f1_idle_busy", a_busy, 0);
    chk("f1_credits", a_credit_viol, 0);

    // Frame 2: pseudo-random backpressure
    prep_a(8'h00);
    start_a(8'h00);
    for (int k = 0; k < 120; k++) begin
      a_if.ready = rdy_pat[k % 16];
      @(posedge clk); #1;
    end
    a_if.ready = 1'b1;
    chk("f2_beats", a_beats, 12);
    chk("f2_dones", a_dones, 1);
    chk("f2_queue_empty", qa.size(), 0);
    chk("f2_credits", a_credit_viol, 0);

    // Frame 3: asynchronous reset after six beats with a read in flight
    prep_a(8'h00);
    start_a(8'h00);
    for (int k = 0; k < 60 && a_beats < 6; k++) @(posedge clk);
    chk("f3_reached_beat6", a_beats, 6);
    #2 rst = 1'b1;
    #1;
    chk("f3_rst_busy_done", {a_busy, a_done}, 0);
    chk("f3_rst_rom", {a_rd_en, a_addr}, 0);
    chk("f3_rst_stream", {a_if.valid, a_if.sof, a_if.eol, a_if.eof, a_if.data}, 0);
    qa.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    a_issued = 0; a_popped = 0;

    // Frame 4: clean restart at base 0
    prep_a(8'h00);
    start_a(8'h00);
    repeat (40) @(posedge clk);
    #1;
    chk("f4_beats", a_beats, 12);
    chk("f4_dones", a_dones, 1);
    chk("f4_queue_empty", qa.size(), 0);

    // DUT B: address wrap from 14
    qb.push_back('{data: 8'hAE, sof: 1'b1, eol: 1'b0, eof: 1'b0});
    qb.push_back('{data: 8'hAF, sof: 1'b0, eol: 1'b1, eof: 1'b0});
    qb.push_back('{data: 8'hA0, sof: 1'b0, eol: 1'b0, eof: 1'b0});
    qb.push_back('{data: 8'hA1, sof: 1'b0, eol: 1'b1, eof: 1'b1});
    b_addrs.delete();
    @(posedge clk); #1;
    b_start = 1'b1; b_base = 4'd14;
    @(posedge clk); #1;
    b_start = 1'b0; b_base = 4'd3;
    repeat (15) @(posedge clk);
    #1;
    chk("b_queue_empty", qb.size(), 0);
    chk("b_addr_count", b_addrs.size(), 4);
    if (b_addrs.size() == 4) begin
      chk("b_addr0", b_addrs[0], 14);
      chk("b_addr1", b_addrs[1], 15);
      chk("b_addr2", b_addrs[2], 0);
      chk("b_addr3", b_addrs[3], 1);
    end

    // DUT C: 1x1 image
    qc.push_back('{data: 8'h5C, sof: 1'b1, eol: 1'b1, eof: 1'b1});
    @(posedge clk); #1;
    c_start = 1'b1; c_base = 8'd7;
    @(posedge clk); #1;
    c_start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("c_queue_empty", qc.size(), 0);
    chk("c_dones", c_dones, 1);
    chk("c_done_timing", c_done_cyc, c_hs_cyc);
    chk("c_busy_end", c_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
